regfile: RTL and testbench



---
 rtl/regfile.sv | 32 +++
 tb/tb_regfile.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32 x 32-bit register file, two combinational read ports, one synchronous write port, $0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        re1,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic        re2,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2
);
   logic [31:0] regs [32];
   logic        byp1, byp2;
   always_ff @(posedge clk)
      if (!rst) regs <= '{default: '0};
      else if (we && waddr != 5'd0) regs[waddr] <= wdata;
`ifdef REGFILE_BYPASS_EN
   assign byp1 = we && raddr1 == waddr;
   assign byp2 = we && raddr2 == waddr;
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif
   always_comb begin
      rdata1 = (!rst || raddr1 == 5'd0 || !re1) ? 32'd0 : byp1 ? wdata : regs[raddr1];
      rdata2 = (!rst || raddr2 == 5'd0 || !re2) ? 32'd0 : byp2 ? wdata : regs[raddr2];
   end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed checks plus a per-cycle comparison against an array model of the register file.
module tb_regfile;
   logic        clk = 1'b0;
   logic        rst, we, re1, re2;
   logic [4:0]  waddr, raddr1, raddr2;
   logic [31:0] wdata, rdata1, rdata2;
   logic [31:0] m [32];
   int          vectors = 0;
   int          miscompares = 0;
   bit          armed = 1'b0;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   regfile dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
      .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!rst) for (int i = 0; i < 32; i++) m[i] = 32'd0;
      else if (we && waddr != 5'd0) m[waddr] = wdata;

   function automatic logic [31:0] expect_rd(input logic re, input logic [4:0] ra);
      if (!rst || ra == 5'd0) return 32'd0;
      if (BYP && re && we && ra == waddr) return wdata;
      return re ? m[ra] : 32'd0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (armed) begin
         chk("model_rdata1", rdata1, expect_rd(re1, raddr1));
         chk("model_rdata2", rdata2, expect_rd(re2, raddr2));
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
      re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd7;
      tick(); tick();
      armed = 1'b1;
      chk("reset_out1", rdata1, 32'd0);
      chk("reset_out2", rdata2, 32'd0);
      // reset clears a preloaded entry
      rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b0; re2 = 1'b0;
      tick();
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd5; #1;
      chk("preload5", rdata1, 32'hDEADBEEF);
      rst = 1'b0; re2 = 1'b1; raddr2 = 5'd5; #1;
      chk("in_reset1", rdata1, 32'd0);
      chk("in_reset2", rdata2, 32'd0);
      tick();
      rst = 1'b1; #1;
      chk("cleared5", rdata1, 32'd0);
      // write then read back on both ports
      we = 1'b1; waddr = 5'd3; wdata = 32'h0000_1234; re1 = 1'b0; re2 = 1'b0;
      tick();
      we = 1'b0; re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3; #1;
      chk("rb1", rdata1, 32'h0000_1234);
      chk("rb2", rdata2, 32'h0000_1234);
      // $0 ignores writes
      we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
      tick();
      we = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0; #1;
      chk("zero1", rdata1, 32'd0);
      chk("zero2", rdata2, 32'd0);
      raddr1 = 5'd3; raddr2 = 5'd5; #1;
      chk("untouched3", rdata1, 32'h0000_1234);
      chk("untouched5", rdata2, 32'd0);
      // same-cycle read/write hazard
      we = 1'b1; waddr = 5'd7; wdata = 32'h11;
      tick();
      wdata = 32'h22; raddr1 = 5'd7; #1;
      chk("hazard_same", rdata1, BYP ? 32'h22 : 32'h11);
      tick();
      we = 1'b0; #1;
      chk("hazard_after", rdata1, 32'h22);
      // read enable gating
      we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
      tick();
      we = 1'b0; raddr2 = 5'd9; re2 = 1'b0; #1;
      chk("re2_off", rdata2, 32'd0);
      re2 = 1'b1; #1;
      chk("re2_on", rdata2, 32'hA5A5A5A5);
      // reset beats a simultaneous write
      rst = 1'b0; we = 1'b1; waddr = 5'd4; wdata = 32'h99;
      tick();
      rst = 1'b1; we = 1'b0; raddr1 = 5'd4; #1;
      chk("reset_wins", rdata1, 32'd0);
      we = 1'b1; wdata = 32'h55;
      tick();
      we = 1'b0; #1;
      chk("post_reset_write", rdata1, 32'h55);
      // mixed traffic checked by the per-cycle model compare
      for (int i = 0; i < 300; i++) begin
         rst = $urandom_range(0, 24) != 0;
         we = $urandom_range(0, 2) != 0;
         waddr = 5'($urandom_range(0, 31));
         wdata = $urandom;
         re1 = $urandom_range(0, 3) != 0;
         re2 = $urandom_range(0, 3) != 0;
         raddr1 = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom_range(0, 31));
         raddr2 = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom_range(0, 31));
         tick();
      end
      rst = 1'b1; we = 1'b0;
      tick();
      armed = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
